regfile_wr_dec_pipe: RTL and testbench

- Parametrised, pipelined write-port decoder for the register file.
- Converts an ADDR_W-bit destination address plus write enable into a one-hot row write-select, delayed through STAGES registered stages to line up with writeback.
- Tracks all in-flight destinations as a pending bitmap for hazard logic.
- Suppresses writes to the hard-wired zero register and supports pipeline flush.

---
 rtl/regfile_wr_dec_pipe.sv | 149 ++++++++++++++
 tb/tb_regfile_wr_dec_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_dec_pipe.sv
// regfile_wr_dec_pipe
// Pipelined write-port decoder for the register file. A destination address
// plus write enable is carried through STAGES registered stages and decoded
// into a one-hot row write-select. The decode is timed to line up with
// writeback. All in-flight destinations are also reported as a pending bitmap
// for hazard detection.
//
// Optional build macro: REGFILE_WR_DEC_ONEHOT_CHK_EN
//   When defined, a sticky checker flags any non-one-hot or inconsistent
//   wr_sel_o / wr_valid_o combination. It is cleared only by reset.
//   When undefined, onehot_err_o is tied low.
//
// Ports:
//   clk_i        - single clock, rising edge
//   reset_i      - synchronous active-high reset
//   wr_en_i      - request a register write this cycle
//   wr_addr_i    - destination register index
//   flush_i      - kill all in-flight writes and this cycle's request
//   wr_sel_o     - one-hot row write-enable, all-zero when idle
//   wr_valid_o   - high exactly when wr_sel_o is non-zero
//   pending_o    - OR of one-hot destinations held in every valid stage
//   drop_cnt_o   - saturating count of writes dropped for targeting ZERO_REG
//   onehot_err_o - sticky decode-integrity error
module regfile_wr_dec_pipe #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned ZERO_EN  = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic                     flush_i,
  output logic [(2**ADDR_W)-1:0]   wr_sel_o,
  output logic                     wr_valid_o,
  output logic [(2**ADDR_W)-1:0]   pending_o,
  output logic [7:0]               drop_cnt_o,
  output logic                     onehot_err_o
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  if (STAGES < 1 || STAGES > 3) begin : gen_stages_check
    $error("regfile_wr_dec_pipe: STAGES must be in 1..3");
  end

  // Stage 0 in the arrays is the first stage; STAGES-1 feeds the decoder.
  logic              valid_q [STAGES];
  logic              valid_d [STAGES];
  logic [ADDR_W-1:0] addr_q  [STAGES];
  logic [ADDR_W-1:0] addr_d  [STAGES];
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic hit_zero;
  logic accept;
  logic drop_inc;

  assign hit_zero = (ZERO_EN != 0) && (wr_addr_i == ZeroAddr);
  assign accept   = wr_en_i & ~flush_i & ~hit_zero;
  assign drop_inc = wr_en_i & ~flush_i & hit_zero;

  always_comb begin
    valid_d[0] = accept;
    addr_d[0]  = wr_addr_i;
    for (int k = 1; k < STAGES; k++) begin
      // No stall: every stage advances each cycle, flush empties the pipe.
      valid_d[k] = valid_q[k-1] & ~flush_i;
      addr_d[k]  = addr_q[k-1];
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        addr_q[k]  <= '0;
      end
      drop_cnt_q <= 8'd0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        addr_q[k]  <= addr_d[k];
      end
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Decode straight from the last stage register; no input-to-output path.
  logic [NUM_REGS-1:0] sel_dec;

  always_comb begin
    sel_dec = '0;
    if (valid_q[STAGES-1]) begin
      sel_dec[addr_q[STAGES-1]] = 1'b1;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (valid_q[k]) begin
        pending_o[addr_q[k]] = 1'b1;
      end
    end
  end

  assign wr_sel_o   = sel_dec;
  assign wr_valid_o = valid_q[STAGES-1];
  assign drop_cnt_o = drop_cnt_q;

`ifdef REGFILE_WR_DEC_ONEHOT_CHK_EN
  localparam logic [NUM_REGS-1:0] SelOne = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic onehot_err_q, onehot_err_d;
  logic multi_hot;

  // x & (x-1) is non-zero iff more than one bit is set.
  assign multi_hot = ((sel_dec & (sel_dec - SelOne)) != '0);

  always_comb begin
    onehot_err_d = onehot_err_q
                 | multi_hot
                 | ((sel_dec != '0) & ~wr_valid_o)
                 | (wr_valid_o & (sel_dec == '0));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      onehot_err_q <= 1'b0;
    end else begin
      onehot_err_q <= onehot_err_d;
    end
  end

  assign onehot_err_o = onehot_err_q;
`else
  assign onehot_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_dec_pipe.sv
// Self-checking bench for regfile_wr_dec_pipe. Two instances share the
// stimulus: one with ZERO_EN = 1 and one with ZERO_EN = 0. A history model
// records which destination was accepted on each recent edge and derives
// wr_sel / pending / drop_cnt from it.
module tb_regfile_wr_dec_pipe;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned STAGES = 2;
  localparam int unsigned NREG   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              flush;

  logic [NREG-1:0] sel1, sel0, pend1, pend0;
  logic            vld1, vld0, err1, err0;
  logic [7:0]      drop1, drop0;

  int tests = 0;
  int fails = 0;

  // Model: hist[k] = address accepted k+1 edges ago that is still alive, or -1.
  int h1 [STAGES];
  int h0 [STAGES];
  int mdrop;

  always #5 clk = ~clk;

  regfile_wr_dec_pipe #(
    .ADDR_W   (ADDR_W),
    .STAGES   (STAGES),
    .ZERO_REG (31),
    .ZERO_EN  (1)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .flush_i      (flush),
    .wr_sel_o     (sel1),
    .wr_valid_o   (vld1),
    .pending_o    (pend1),
    .drop_cnt_o   (drop1),
    .onehot_err_o (err1)
  );

  regfile_wr_dec_pipe #(
    .ADDR_W   (ADDR_W),
    .STAGES   (STAGES),
    .ZERO_REG (31),
    .ZERO_EN  (0)
  ) dut0 (
    .clk_i        (clk),
    .reset_i      (reset),
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .flush_i      (flush),
    .wr_sel_o     (sel0),
    .wr_valid_o   (vld0),
    .pending_o    (pend0),
    .drop_cnt_o   (drop0),
    .onehot_err_o (err0)
  );

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input int addr, input logic fl, input logic rst);
    wr_en   = en;
    wr_addr = ADDR_W'(addr);
    flush   = fl;
    reset   = rst;
  endtask

  function automatic logic [31:0] m_sel(input int last);
    logic [31:0] one;
    one = 32'd1;
    return (last >= 0) ? (one << last) : 32'd0;
  endfunction

  task automatic model_edge();
    if (reset || flush) begin
      for (int k = 0; k < STAGES; k++) begin
        h1[k] = -1;
        h0[k] = -1;
      end
      if (reset) mdrop = 0;
    end else begin
      for (int k = STAGES - 1; k > 0; k--) begin
        h1[k] = h1[k-1];
        h0[k] = h0[k-1];
      end
      h1[0] = (wr_en && wr_addr != 5'd31) ? int'(wr_addr) : -1;
      h0[0] = wr_en ? int'(wr_addr) : -1;
      if (wr_en && wr_addr == 5'd31 && mdrop < 255) mdrop++;
    end
  endtask

  task automatic model_check(input string tag);
    logic [31:0] p1, p0;
    p1 = '0;
    p0 = '0;
    for (int k = 0; k < STAGES; k++) begin
      p1 |= m_sel(h1[k]);
      p0 |= m_sel(h0[k]);
    end
    cmp({tag, ".sel1"},  sel1,  m_sel(h1[STAGES-1]));
    cmp({tag, ".vld1"},  {31'd0, vld1}, {31'd0, h1[STAGES-1] >= 0});
    cmp({tag, ".pend1"}, pend1, p1);
    cmp({tag, ".drop1"}, {24'd0, drop1}, mdrop);
    cmp({tag, ".err1"},  {31'd0, err1}, 32'd0);
    cmp({tag, ".sel0"},  sel0,  m_sel(h0[STAGES-1]));
    cmp({tag, ".vld0"},  {31'd0, vld0}, {31'd0, h0[STAGES-1] >= 0});
    cmp({tag, ".pend0"}, pend0, p0);
    cmp({tag, ".drop0"}, {24'd0, drop0}, 32'd0);
  endtask

  // Inputs are already applied; advance one edge, update the model, sample later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    model_check(tag);
  endtask

  initial begin
    for (int k = 0; k < STAGES; k++) begin
      h1[k] = -1;
      h0[k] = -1;
    end
    mdrop = 0;
    drive(1'b0, 0, 1'b0, 1'b1);
    step("rst0");
    step("rst1");
    cmp("rst.sel", sel1, 32'd0);
    cmp("rst.pend", pend1, 32'd0);

    // Single write to r5: pending one edge later, wr_sel on the second edge.
    drive(1'b1, 5, 1'b0, 1'b0);
    step("w5a");
    cmp("w5.pend_e1", pend1, 32'h0000_0020);
    cmp("w5.sel_e1", sel1, 32'd0);
    drive(1'b0, 0, 1'b0, 1'b0);
    step("w5b");
    cmp("w5.sel_e2", sel1, 32'h0000_0020);
    cmp("w5.vld_e2", {31'd0, vld1}, 32'd1);
    cmp("w5.pend_e2", pend1, 32'h0000_0020);
    step("w5c");
    cmp("w5.sel_e3", sel1, 32'd0);
    cmp("w5.pend_e3", pend1, 32'd0);

    // Back-to-back 3, 4, 3.
    drive(1'b1, 3, 1'b0, 1'b0);
    step("b2b_a");
    drive(1'b1, 4, 1'b0, 1'b0);
    step("b2b_b");
    cmp("b2b.sel_b", sel1, 32'h8);
    cmp("b2b.pend_b", pend1, 32'h18);
    drive(1'b1, 3, 1'b0, 1'b0);
    step("b2b_c");
    cmp("b2b.sel_c", sel1, 32'h10);
    cmp("b2b.pend_c", pend1, 32'h18);
    drive(1'b0, 0, 1'b0, 1'b0);
    step("b2b_d");
    cmp("b2b.sel_d", sel1, 32'h8);
    step("b2b_e");

    // Flush with 7 and 9 in flight and a concurrent request to r2.
    drive(1'b1, 7, 1'b0, 1'b0);
    step("fl_a");
    drive(1'b1, 9, 1'b0, 1'b0);
    step("fl_b");
    drive(1'b1, 2, 1'b1, 1'b0);
    step("fl_c");
    cmp("flush.pend", pend1, 32'd0);
    cmp("flush.sel", sel1, 32'd0);
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < STAGES; i++) begin
      step("fl_after");
      cmp("flush.sel_after", sel1, 32'd0);
    end

    // Flush together with a zero-register write: no drop counted.
    drive(1'b1, 31, 1'b1, 1'b0);
    step("fl_zero");
    cmp("flush.zero_drop", {24'd0, drop1}, 32'd0);

    // Reset mid-operation with a concurrent request.
    drive(1'b1, 7, 1'b0, 1'b0);
    step("rs_a");
    drive(1'b1, 9, 1'b0, 1'b0);
    step("rs_b");
    drive(1'b1, 4, 1'b0, 1'b1);
    step("rs_c");
    cmp("midrst.pend", pend1, 32'd0);
    cmp("midrst.sel", sel1, 32'd0);
    drive(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < STAGES + 1; i++) begin
      step("rs_after");
      cmp("midrst.sel_after", sel1, 32'd0);
    end

    // 300 writes to the zero register.
    drive(1'b1, 31, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step("zero");
    cmp("zero.drop_sat", {24'd0, drop1}, 32'd255);
    cmp("zero.sel", sel1, 32'd0);
    cmp("zero.pend", pend1, 32'd0);
    cmp("zero_en0.sel", sel0, 32'h8000_0000);
    cmp("zero_en0.drop", {24'd0, drop0}, 32'd0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
      step("rand");
    end

`ifdef REGFILE_WR_DEC_ONEHOT_CHK_EN
    drive(1'b0, 0, 1'b0, 1'b1);
    step("chk_rst");
    drive(1'b0, 0, 1'b0, 1'b0);
    force dut.sel_dec = 32'h0000_0003;
    @(posedge clk);
    #1;
    release dut.sel_dec;
    @(posedge clk);
    #1;
    cmp("chk.err_set", {31'd0, err1}, 32'd1);
    drive(1'b0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cmp("chk.err_flush", {31'd0, err1}, 32'd1);
    drive(1'b0, 0, 1'b0, 1'b1);
    step("chk_clr");
    cmp("chk.err_clr", {31'd0, err1}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
